// File: rtl/sci_slave.sv
// sci_slave: bit-serial register-access slave on the SCI bus.
//   Decodes a WNR/address/write-data frame into one-cycle local register strobes and
//   returns read data serially, MSB first, followed by a one-cycle ACK.
// Ports:
//   CLK, RST            - clock and asynchronous active-high reset
//   SCI_CSN, SCI_REQ    - chip select (active-low) and serial request line from master
//   SCI_RESP, SCI_ACK   - shared open bus lines, high-Z whenever this slave is deselected
//   REG_ADDR, REG_WDATA - local register address / write data, held until the next frame
//   REG_WE, REG_RE      - one-cycle local write / read strobes
//   REG_RDATA           - local read data, valid the cycle after REG_RE
module sci_slave #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  SCI_CSN,
   input  logic                  SCI_REQ,
   inout  wire                   SCI_RESP,
   inout  wire                   SCI_ACK,
   output logic [ADDR_WIDTH-1:0] REG_ADDR,
   output logic [DATA_WIDTH-1:0] REG_WDATA,
   output logic                  REG_WE,
   output logic                  REG_RE,
   input  logic [DATA_WIDTH-1:0] REG_RDATA
);

   localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_WRITE,
      S_RD_REQ,
      S_RD_LOAD,
      S_RD_SHIFT,
      S_ACK,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CW-1:0]         r_cnt;
   logic [CW-1:0]         w_cnt_nxt;
   logic                  r_wnr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rsh;

   logic                  w_cap_wnr;
   logic                  w_sh_addr;
   logic                  w_sh_wdata;
   logic                  w_ld_rd;
   logic                  w_sh_rd;
   logic                  w_resp;
   logic                  w_ack;

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath control
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap_wnr   = 1'b0;
      w_sh_addr   = 1'b0;
      w_sh_wdata  = 1'b0;
      w_ld_rd     = 1'b0;
      w_sh_rd     = 1'b0;

      if (r_state != S_IDLE && SCI_CSN) begin
         // Master deselected mid-frame: drop the frame. A strobe decoded from the
         // current state still completes this cycle, nothing follows it.
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!SCI_CSN) begin
                  w_cap_wnr   = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_ADDR;
               end
            end
            S_ADDR: begin
               w_sh_addr = 1'b1;
               if (r_cnt == ADDR_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = r_wnr ? S_WDATA : S_RD_REQ;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_WDATA: begin
               w_sh_wdata = 1'b1;
               if (r_cnt == DATA_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_WRITE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_WRITE:   w_state_nxt = S_ACK;
            S_RD_REQ:  w_state_nxt = S_RD_LOAD;
            S_RD_LOAD: begin
               w_ld_rd     = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_RD_SHIFT;
            end
            S_RD_SHIFT: begin
               w_sh_rd = 1'b1;
               if (r_cnt == DATA_LAST) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_ACK;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_ACK:   w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;   // leaves only through deselect
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Datapath registers
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt   <= '0;
         r_wnr   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rsh   <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_cap_wnr)  r_wnr   <= SCI_REQ;
         if (w_sh_addr)  r_addr  <= (r_addr << 1) | ADDR_WIDTH'(SCI_REQ);
         if (w_sh_wdata) r_wdata <= (r_wdata << 1) | DATA_WIDTH'(SCI_REQ);
         if (w_ld_rd)         r_rsh <= REG_RDATA;
         else if (w_sh_rd)    r_rsh <= r_rsh << 1;
      end
   end

   // Moore outputs: decoded only from registered state
   assign REG_WE    = (r_state == S_WRITE);
   assign REG_RE    = (r_state == S_RD_REQ);
   assign w_ack     = (r_state == S_ACK);
   assign w_resp    = (r_state == S_RD_SHIFT) ? r_rsh[DATA_WIDTH-1] : 1'b0;
   assign REG_ADDR  = r_addr;
   assign REG_WDATA = r_wdata;

   // Shared lines are released whenever this slave is not selected
   assign SCI_RESP = SCI_CSN ? 1'bz : w_resp;
   assign SCI_ACK  = SCI_CSN ? 1'bz : w_ack;

endmodule

// File: doc/sci_slave.md
SCI_SLAVE -- requirements
Module: sci_slave

Interface
REQ-001 Parameters: ADDR_WIDTH, default 5, register address bits per frame; DATA_WIDTH, default 32, register data bits per frame.
REQ-002 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 SCI_CSN  input  1  chip select from SCI master, active-low, one bit of the master's CSN bus.
REQ-005 SCI_REQ  input  1  serial command/address/write-data line from master.
REQ-006 SCI_RESP  inout  1  serial read-data line back to master, shared by all slaves.
REQ-007 SCI_ACK  inout  1  transaction-complete line back to master, shared by all slaves.
REQ-008 REG_ADDR  output  ADDR_WIDTH  local register address, held from address capture until next frame.
REQ-009 REG_WDATA  output  DATA_WIDTH  local register write data.
REQ-010 REG_WE  output  1  one-cycle local write strobe.
REQ-011 REG_RE  output  1  one-cycle local read strobe.
REQ-012 REG_RDATA  input  DATA_WIDTH  local read data, valid the cycle after REG_RE.

Function
REQ-013 Frame: while SCI_CSN=0, one SCI_REQ bit per CLK: WNR (1=write), then ADDR_WIDTH address bits MSB first, then (writes only) DATA_WIDTH data bits MSB first.
REQ-014 States: IDLE, ADDR, WDATA, WRITE, RD_REQ, RD_LOAD, RD_SHIFT, ACK, DONE; one bit counter sized for max(ADDR_WIDTH, DATA_WIDTH).
REQ-015 IDLE: SCI_CSN=0 sampled -> capture SCI_REQ as WNR, clear counter, go ADDR.
REQ-016 ADDR: shift SCI_REQ into REG_ADDR LSB each cycle; after ADDR_WIDTH bits -> WDATA if WNR=1, else RD_REQ.
REQ-017 WDATA: shift SCI_REQ into REG_WDATA LSB each cycle; after DATA_WIDTH bits -> WRITE.
REQ-018 WRITE: REG_WE=1 for exactly this cycle, REG_ADDR/REG_WDATA stable -> ACK.
REQ-019 RD_REQ: REG_RE=1 for exactly this cycle -> RD_LOAD; RD_LOAD: load REG_RDATA into read shift register -> RD_SHIFT.
REQ-020 RD_SHIFT: SCI_RESP = shift-register MSB, shift left one per cycle, DATA_WIDTH cycles -> ACK.
REQ-021 ACK: SCI_ACK=1 for exactly one cycle -> DONE; DONE: wait for SCI_CSN=1 -> IDLE; SCI_REQ ignored in DONE.
REQ-022 REG_WE, REG_RE, SCI_ACK, SCI_RESP decoded from registered state only (Moore), glitch-free.
REQ-023 Tristate: SCI_RESP and SCI_ACK high-Z whenever SCI_CSN=1; when SCI_CSN=0, driven 0 except as per REQ-020/REQ-021.
REQ-024 Abort: SCI_CSN=1 sampled in any non-IDLE state -> IDLE next cycle; no REG_WE, REG_RE or SCI_ACK generated after the abort edge; a REG_WE/REG_RE already asserted in that cycle completes.
REQ-025 Back-to-back frames: SCI_CSN must pass through 1 for >=1 cycle; frame starts only from IDLE.
REQ-026 Write latency: REG_WE in cycle 1+ADDR_WIDTH+DATA_WIDTH counting WNR cycle as 0; SCI_ACK the following cycle (defaults: cycles 38, 39).
REQ-027 Read latency: REG_RE in cycle 1+ADDR_WIDTH; first RESP bit in cycle 3+ADDR_WIDTH; SCI_ACK in cycle 3+ADDR_WIDTH+DATA_WIDTH (defaults: 6, 8, 40).

Reset
REQ-028 RST=1 asynchronously forces IDLE, counter 0, REG_ADDR 0, REG_WDATA 0, read shift register 0, REG_WE 0, REG_RE 0.
REQ-029 During and after reset, SCI_RESP/SCI_ACK follow REQ-023 (high-Z when SCI_CSN=1, 0 when SCI_CSN=0).
REQ-030 RST asserted mid-frame: no strobe or ACK emitted; after release, slave waits in IDLE; if SCI_CSN still 0 at release, the next sampled SCI_REQ is treated as WNR.

Verification
REQ-031 Write addr 5'h13 data 32'hDEADBEEF -> REG_WE one cycle at cycle 38 with REG_ADDR=5'h13, REG_WDATA=32'hDEADBEEF; SCI_ACK=1 at cycle 39 only.
REQ-032 Read addr 5'h07, REG_RDATA=32'hA5A5_0F0F -> REG_RE at cycle 6; SCI_RESP bits 1,0,1,0,... MSB first cycles 8..39; SCI_ACK at cycle 40.
REQ-033 Write aborted by SCI_CSN=1 after 20 data bits -> no REG_WE, no SCI_ACK, IDLE next cycle; subsequent full write to 5'h01 succeeds normally.
REQ-034 SCI_CSN=1 throughout random SCI_REQ toggling -> SCI_RESP and SCI_ACK remain Z, no strobes.
REQ-035 RST pulsed at cycle 10 of a read -> no REG_RE beyond cycle 6 strobe, no RESP data, no SCI_ACK; outputs at reset values.
REQ-036 Two back-to-back writes (1-cycle CSN gap) to 5'h00, 5'h1F -> two REG_WE pulses, two SCI_ACK pulses, correct addresses/data.
